// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SDRAM access arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   typedef enum logic [1:0] {ID_VID, ID_BUS, ID_CPY} req_id_t;

   localparam logic [1:0] WTBT_FULL = 2'b11;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector: video first, then bus, then copy, except that
// copy jumps ahead of bus once it has been starved for too long.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [2:0] req,      // {cpy, bus, vid}, already masked
   input  logic       starve,
   output logic [2:0] gnt,
   output req_id_t    gnt_id
);

   always_comb begin
      gnt    = 3'b000;
      gnt_id = ID_VID;
      if (req[0]) begin
         gnt    = 3'b001;
         gnt_id = ID_VID;
      end else if (starve && req[2]) begin
         gnt    = 3'b100;
         gnt_id = ID_CPY;
      end else if (req[1]) begin
         gnt    = 3'b010;
         gnt_id = ID_BUS;
      end else if (req[2]) begin
         gnt    = 3'b100;
         gnt_id = ID_CPY;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SDRAM arbiter for video, CPU bus and OSD copy requesters.
// Each access is sequenced issue -> wait -> acknowledge, with a completion timeout.
//
//   state | meaning
//   IDLE  | arbitrate; latch winner's command
//   ISSUE | one-cycle mem_we/mem_rd strobe, clear timeout
//   WAIT  | wait for mem_ready or timeout
//   DONE  | one-cycle ack (and err if aborted)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int COPY_MAX_WAIT = 8,
   parameter int TIMEOUT       = 63
) (
   input  logic        clk_ram,
   input  logic        reset,
   input  logic        vid_req,
   input  logic        bus_req,
   input  logic        cpy_req,
   input  logic [23:0] vid_addr,
   input  logic [23:0] bus_addr,
   input  logic [23:0] cpy_addr,
   input  logic [15:0] bus_din,
   input  logic [15:0] cpy_din,
   input  logic [1:0]  bus_wtbt,
   input  logic        bus_we,
   input  logic        cpy_we,
   output logic        vid_ack,
   output logic        bus_ack,
   output logic        cpy_ack,
   output logic [15:0] vid_dout,
   output logic [15:0] bus_dout,
   output logic [15:0] cpy_dout,
   output logic        err,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_wtbt,
   output logic        mem_we,
   output logic        mem_rd,
   input  logic [15:0] mem_dout,
   input  logic        mem_ready
);

   localparam int SW = $clog2(COPY_MAX_WAIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t       state;
   logic [2:0]   cur_oh;
   logic         cur_we;
   logic         aborted;
   logic [23:0]  lat_addr;
   logic [15:0]  lat_din;
   logic [1:0]   lat_wtbt;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [TW-1:0] tmo_nxt;
   logic         tmo_hit;
   logic [2:0]   mask_oh;
   logic [2:0]   req_elig;
   logic [2:0]   gnt;
   req_id_t      gnt_id;
   logic         starve;
   logic [23:0]  sel_addr;
   logic [15:0]  sel_din;
   logic [1:0]   sel_wtbt;
   logic         sel_we;

   // The requester just served sits out one IDLE cycle so it can drop req.
   assign req_elig = {cpy_req, bus_req, vid_req} & ~mask_oh;
   assign starve   = (starve_cnt == SW'(COPY_MAX_WAIT));
   assign tmo_nxt  = tmo_cnt + TW'(1);
   assign tmo_hit  = (tmo_nxt == TW'(TIMEOUT));

   mem_arb_pick u_pick (
      .req    (req_elig),
      .starve (starve),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      sel_addr = vid_addr;
      sel_din  = '0;
      sel_wtbt = WTBT_FULL;
      sel_we   = 1'b0;
      case (gnt_id)
         ID_BUS: begin
            sel_addr = bus_addr;
            sel_din  = bus_din;
            sel_wtbt = bus_wtbt;
            sel_we   = bus_we;
         end
         ID_CPY: begin
            sel_addr = cpy_addr;
            sel_din  = cpy_din;
            sel_wtbt = WTBT_FULL;
            sel_we   = cpy_we;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_ram) begin
      if (reset) begin
         state      <= IDLE;
         cur_oh     <= '0;
         cur_we     <= 1'b0;
         aborted    <= 1'b0;
         lat_addr   <= '0;
         lat_din    <= '0;
         lat_wtbt   <= '0;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         mask_oh    <= '0;
         vid_dout   <= '0;
         bus_dout   <= '0;
         cpy_dout   <= '0;
      end else begin
         case (state)
            IDLE: begin
               mask_oh <= '0;
               if (gnt[2] || !cpy_req)
                  starve_cnt <= '0;
               else if (gnt[1] && !starve)
                  starve_cnt <= starve_cnt + SW'(1);
               if (|gnt) begin
                  cur_oh   <= gnt;
                  cur_we   <= sel_we;
                  lat_addr <= sel_addr;
                  lat_din  <= sel_din;
                  lat_wtbt <= sel_wtbt;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               tmo_cnt <= '0;
               aborted <= 1'b0;
               state   <= WAIT;
            end
            WAIT: begin
               if (mem_ready) begin
                  if (!cur_we) begin
                     if (cur_oh[0]) vid_dout <= mem_dout;
                     if (cur_oh[1]) bus_dout <= mem_dout;
                     if (cur_oh[2]) cpy_dout <= mem_dout;
                  end
                  state <= DONE;
               end else if (tmo_hit) begin
                  aborted <= 1'b1;
                  state   <= DONE;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end
            DONE: begin
               mask_oh <= cur_oh;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_rd   = (state == ISSUE) && !cur_we;
   assign mem_we   = (state == ISSUE) &&  cur_we;
   assign mem_addr = lat_addr;
   assign mem_din  = lat_din;
   assign mem_wtbt = lat_wtbt;
   assign vid_ack  = (state == DONE) && cur_oh[0];
   assign bus_ack  = (state == DONE) && cur_oh[1];
   assign cpy_ack  = (state == DONE) && cur_oh[2];
   assign err      = (state == DONE) && aborted;

endmodule
